conv_layer_fx: RTL and testbench
================================

# conv_layer_fx

Fixed-point, parametrised successor of the floating-point convolution layer. It holds per-layer activation, weight, bias and output memories and computes one output pixel per K×K+1 cycles, with all input channels reduced in parallel. It adds configurable stride and zero padding, saturating fixed-point arithmetic, optional ReLU, and a start/busy/done handshake. It sits between layer loaders and the next layer's activation load path in the DNN pipeline.

## Interface
- NUM_INPUTS, 1, input channels (parallel MAC lanes)
- NUM_OUTPUTS, 1, output channels (kernels)
- IN_DIM, 5, input feature-map width and height
- KERNEL_DIM, 3, kernel width and height
- STRIDE, 1, convolution stride (≥1)
- PAD, 0, zero padding on each border
- DATA_W, 16, signed data, weight and bias width
- FRAC_W, 8, fractional bits (Q(DATA_W-FRAC_W).FRAC_W)
- ACC_W, 40, signed accumulator width
- RELU_EN, 1, clamp negative outputs to 0
- OUT_DIM, (IN_DIM+2*PAD-KERNEL_DIM)/STRIDE+1, derived; do not override
- clk  in  1  clock; single clock domain
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  begin computation; sampled in IDLE or DONE
- busy  out  1  high in MAC/FIN
- done  out  1  high in DONE until next accepted start
- act_we, act_ch, act_y, act_x, act_wdata  in  1/16/16/16/DATA_W  activation write
- wt_we, wt_in, wt_out, wt_ky, wt_kx, wt_wdata  in  1/16×4/DATA_W  weight write
- bias_we, bias_idx, bias_wdata  in  1/16/DATA_W  bias write
- rd_ch, rd_y, rd_x  in  16 each  output-memory read address
- rd_data  out  DATA_W  combinational output-memory read

## Operation
- States: IDLE → (start) MAC → FIN → MAC … → DONE → (start) MAC.
- Loop order, outer to inner: oc, oy, ox, ky, kx; all counters are cleared on start.
- MAC: each lane i computes acc[i] += w[oc][i][ky][kx] * a[i][iy][ix], where iy = oy*STRIDE+ky-PAD and ix = ox*STRIDE+kx-PAD.
  - If iy or ix is outside [0,IN_DIM-1], the activation operand is 0 (padding).
  - acc[i] is cleared when ky=kx=0 (overwritten, not added).
  - Products are 2·DATA_W wide and sign-extended to ACC_W.
- FIN, one cycle, in order:
  - sum = Σacc[i] + (bias[oc] <<< FRAC_W)
  - round-half-up: add 1<<(FRAC_W-1), then arithmetic shift right by FRAC_W
  - saturate to [−2^(DATA_W−1), 2^(DATA_W−1)−1]
  - if RELU_EN, clamp negative to 0
  - write out_mem[oc][oy][ox]
- Last pixel (oc=NUM_OUTPUTS−1, oy=ox=OUT_DIM−1): FIN → DONE. Otherwise FIN → MAC with advanced counters.
- Load writes (act/wt/bias) take effect only in IDLE or DONE. While busy they are ignored.
- Out-of-range write indices are ignored. Out-of-range read indices return 0.
- start while busy is ignored. start in DONE restarts and clears done.
- Simultaneous start and load write in IDLE: the write commits and start is accepted in the same cycle; the computation sees the new value.

## Timing
- Reset (async assert, sync deassert handled externally): state=IDLE, busy=0, done=0, all counters and accumulators 0; memories not cleared.
- start accepted at edge t: busy=1 from t+1.
- Total latency from the start edge to done=1: NUM_OUTPUTS·OUT_DIM²·(KERNEL_DIM²+1)+1 cycles.
- An output word is readable on rd_data the cycle after its FIN edge.
- rst_n low mid-operation: immediate return to IDLE; output memory keeps partial results; done=0.

## Structure
- Package conv_fx_pkg: state enum (IDLE, MAC, FIN, DONE), index width constant (16), and the saturate/round functions parametrised by DATA_W/FRAC_W.
- One sub-module, conv_fx_addr_gen: owns the oc/oy/ox/ky/kx counters, padding-aware iy/ix generation, in_bounds flag, and last_tap/last_pixel flags.
- Memories are register arrays inside conv_layer_fx.

## Test plan
- Identity kernel: DATA_W=16, FRAC_W=8, IN_DIM=5, K=3, centre weight 0x0100, bias 0, act[y][x]=(y*5+x)<<8 → 3×3 output equals the centre 3×3 input; done after 9·10+1 = 91 cycles.
- Padding/stride: PAD=1, STRIDE=2, all-ones (0x0100) activations and weights, IN_DIM=5 → OUT_DIM=3; corners = 4.0 (0x0400), edges = 6.0 (0x0600), centre = 9.0 (0x0900).
- Saturation/ReLU: weights 0x7F00, activations 0x7F00 → output 0x7FFF. Weights negated → 0 with RELU_EN=1, 0x8000 with RELU_EN=0.
- Multi-channel: NUM_INPUTS=2, NUM_OUTPUTS=2, bias[1]=−0.5 (0xFF80) → ch1 = lane sum − 0.5, round-half-up checked on a result of x.5/256.
- Handshake: start while busy ignored; load write while busy ignored (result unchanged); restart from DONE clears done next cycle.
- Reset mid-run: rst_n low during MAC → busy=0 and done=0 immediately. A subsequent start produces the full correct result.

Source files
------------

// File: rtl/conv_fx_pkg.sv
// Shared types and fixed-point helpers for the fixed-point convolution layer.
// Round/saturate work on a 64-bit intermediate so any DATA_W/FRAC_W/ACC_W up to ~60 bits fits.
package conv_fx_pkg;
   localparam int IDX_W = 16;

   typedef enum logic [1:0] {ST_IDLE, ST_MAC, ST_FIN, ST_DONE} state_e;

   function automatic int clog2w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Round half up, then drop FRAC_W fractional bits.
   function automatic logic signed [63:0] round_hu(input logic signed [63:0] v, input int frac_w);
      if (frac_w == 0) return v;
      return (v + (64'sd1 <<< (frac_w - 1))) >>> frac_w;
   endfunction

   function automatic logic signed [63:0] sat(input logic signed [63:0] v, input int data_w);
      logic signed [63:0] hi, lo;
      hi = (64'sd1 <<< (data_w - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (data_w - 1));
      if (v > hi) return hi;
      if (v < lo) return lo;
      return v;
   endfunction
endpackage

// File: rtl/conv_fx_addr_gen.sv
// Loop counters (oc, oy, ox, ky, kx) plus padding-aware input coordinates.
module conv_fx_addr_gen
   import conv_fx_pkg::*;
#(
   parameter int NUM_OUTPUTS = 1,
   parameter int IN_DIM      = 5,
   parameter int KERNEL_DIM  = 3,
   parameter int STRIDE      = 1,
   parameter int PAD         = 0,
   parameter int OUT_DIM     = 3
)(
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    i_clear,
   input  logic                    i_tap,
   input  logic                    i_pix,
   output logic [IDX_W-1:0]        o_oc,
   output logic [IDX_W-1:0]        o_oy,
   output logic [IDX_W-1:0]        o_ox,
   output logic [IDX_W-1:0]        o_ky,
   output logic [IDX_W-1:0]        o_kx,
   output logic signed [31:0]      o_iy,
   output logic signed [31:0]      o_ix,
   output logic                    o_in_bounds,
   output logic                    o_last_tap,
   output logic                    o_last_pixel
);
   localparam logic [IDX_W-1:0] ONE   = IDX_W'(1);
   localparam logic [IDX_W-1:0] K_MAX = IDX_W'(KERNEL_DIM - 1);
   localparam logic [IDX_W-1:0] O_MAX = IDX_W'(OUT_DIM - 1);
   localparam logic [IDX_W-1:0] C_MAX = IDX_W'(NUM_OUTPUTS - 1);

   logic [IDX_W-1:0] r_oc, r_oy, r_ox, r_ky, r_kx;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_oc <= '0; r_oy <= '0; r_ox <= '0; r_ky <= '0; r_kx <= '0;
      end else if (i_clear) begin
         r_oc <= '0; r_oy <= '0; r_ox <= '0; r_ky <= '0; r_kx <= '0;
      end else if (i_tap) begin
         if (r_kx == K_MAX) begin
            r_kx <= '0;
            r_ky <= (r_ky == K_MAX) ? '0 : r_ky + ONE;
         end else begin
            r_kx <= r_kx + ONE;
         end
      end else if (i_pix) begin
         if (r_ox == O_MAX) begin
            r_ox <= '0;
            if (r_oy == O_MAX) begin
               r_oy <= '0;
               r_oc <= (r_oc == C_MAX) ? '0 : r_oc + ONE;
            end else begin
               r_oy <= r_oy + ONE;
            end
         end else begin
            r_ox <= r_ox + ONE;
         end
      end
   end

   assign o_oc = r_oc;
   assign o_oy = r_oy;
   assign o_ox = r_ox;
   assign o_ky = r_ky;
   assign o_kx = r_kx;
   assign o_iy = int'(r_oy) * STRIDE + int'(r_ky) - PAD;
   assign o_ix = int'(r_ox) * STRIDE + int'(r_kx) - PAD;
   assign o_in_bounds  = (o_iy >= 0) && (o_iy < IN_DIM) && (o_ix >= 0) && (o_ix < IN_DIM);
   assign o_last_tap   = (r_ky == K_MAX) && (r_kx == K_MAX);
   assign o_last_pixel = (r_oc == C_MAX) && (r_oy == O_MAX) && (r_ox == O_MAX);
endmodule

// File: rtl/conv_layer_fx.sv
// Fixed-point KxK convolution layer: one output pixel per K*K+1 cycles, all input
// channels reduced in parallel lanes, with stride, zero padding, saturation and ReLU.
module conv_layer_fx
   import conv_fx_pkg::*;
#(
   parameter int NUM_INPUTS  = 1,
   parameter int NUM_OUTPUTS = 1,
   parameter int IN_DIM      = 5,
   parameter int KERNEL_DIM  = 3,
   parameter int STRIDE      = 1,
   parameter int PAD         = 0,
   parameter int DATA_W      = 16,
   parameter int FRAC_W      = 8,
   parameter int ACC_W       = 40,
   parameter int RELU_EN     = 1,
   parameter int OUT_DIM     = (IN_DIM + 2*PAD - KERNEL_DIM) / STRIDE + 1
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_start,
   output logic              o_busy,
   output logic              o_done,
   input  logic              i_act_we,
   input  logic [IDX_W-1:0]  i_act_ch,
   input  logic [IDX_W-1:0]  i_act_y,
   input  logic [IDX_W-1:0]  i_act_x,
   input  logic [DATA_W-1:0] i_act_wdata,
   input  logic              i_wt_we,
   input  logic [IDX_W-1:0]  i_wt_in,
   input  logic [IDX_W-1:0]  i_wt_out,
   input  logic [IDX_W-1:0]  i_wt_ky,
   input  logic [IDX_W-1:0]  i_wt_kx,
   input  logic [DATA_W-1:0] i_wt_wdata,
   input  logic              i_bias_we,
   input  logic [IDX_W-1:0]  i_bias_idx,
   input  logic [DATA_W-1:0] i_bias_wdata,
   input  logic [IDX_W-1:0]  i_rd_ch,
   input  logic [IDX_W-1:0]  i_rd_y,
   input  logic [IDX_W-1:0]  i_rd_x,
   output logic [DATA_W-1:0] o_rd_data
);
   localparam int ACT_N  = NUM_INPUTS * IN_DIM * IN_DIM;
   localparam int WT_N   = NUM_OUTPUTS * NUM_INPUTS * KERNEL_DIM * KERNEL_DIM;
   localparam int OUT_N  = NUM_OUTPUTS * OUT_DIM * OUT_DIM;
   localparam int ACT_AW = clog2w(ACT_N);
   localparam int WT_AW  = clog2w(WT_N);
   localparam int OUT_AW = clog2w(OUT_N);
   localparam int B_AW   = clog2w(NUM_OUTPUTS);

   state_e r_state, w_next;
   logic   w_load_ok, w_accept, w_tap, w_pix, w_first_tap;
   logic   w_inb, w_last_tap, w_last_pix;
   logic [IDX_W-1:0]   w_oc, w_oy, w_ox, w_ky, w_kx;
   logic signed [31:0] w_iy, w_ix;

   logic signed [DATA_W-1:0]   r_act  [ACT_N];
   logic signed [DATA_W-1:0]   r_wt   [WT_N];
   logic signed [DATA_W-1:0]   r_bias [NUM_OUTPUTS];
   logic signed [DATA_W-1:0]   r_out  [OUT_N];
   logic signed [ACC_W-1:0]    r_acc  [NUM_INPUTS];
   logic signed [2*DATA_W-1:0] w_prod [NUM_INPUTS];
   logic signed [63:0]         w_sum, w_rnd;
   logic signed [DATA_W-1:0]   w_res;

   assign w_load_ok = (r_state == ST_IDLE) || (r_state == ST_DONE);
   assign w_accept  = i_start && w_load_ok;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE, ST_DONE: if (i_start) w_next = ST_MAC;
         ST_MAC:           if (w_last_tap) w_next = ST_FIN;
         ST_FIN:           w_next = w_last_pix ? ST_DONE : ST_MAC;
         default:          w_next = ST_IDLE;
      endcase
   end

   always_comb begin
      o_busy = 1'b0;
      o_done = 1'b0;
      w_tap  = 1'b0;
      w_pix  = 1'b0;
      case (r_state)
         ST_MAC:  begin o_busy = 1'b1; w_tap = 1'b1; end
         ST_FIN:  begin o_busy = 1'b1; w_pix = 1'b1; end
         ST_DONE: o_done = 1'b1;
         default: ;
      endcase
   end

   conv_fx_addr_gen #(
      .NUM_OUTPUTS(NUM_OUTPUTS), .IN_DIM(IN_DIM), .KERNEL_DIM(KERNEL_DIM),
      .STRIDE(STRIDE), .PAD(PAD), .OUT_DIM(OUT_DIM)
   ) u_addr (
      .clk(clk), .rst_n(rst_n), .i_clear(w_accept), .i_tap(w_tap), .i_pix(w_pix),
      .o_oc(w_oc), .o_oy(w_oy), .o_ox(w_ox), .o_ky(w_ky), .o_kx(w_kx),
      .o_iy(w_iy), .o_ix(w_ix), .o_in_bounds(w_inb),
      .o_last_tap(w_last_tap), .o_last_pixel(w_last_pix)
   );

   // Loads are only honoured while idle/done, so a start in the same cycle sees them.
   always_ff @(posedge clk) begin
      if (w_load_ok && i_act_we && i_act_ch < IDX_W'(NUM_INPUTS) &&
          i_act_y < IDX_W'(IN_DIM) && i_act_x < IDX_W'(IN_DIM))
         r_act[ACT_AW'((int'(i_act_ch)*IN_DIM + int'(i_act_y))*IN_DIM + int'(i_act_x))] <= i_act_wdata;
      if (w_load_ok && i_wt_we && i_wt_out < IDX_W'(NUM_OUTPUTS) && i_wt_in < IDX_W'(NUM_INPUTS) &&
          i_wt_ky < IDX_W'(KERNEL_DIM) && i_wt_kx < IDX_W'(KERNEL_DIM))
         r_wt[WT_AW'(((int'(i_wt_out)*NUM_INPUTS + int'(i_wt_in))*KERNEL_DIM + int'(i_wt_ky))*KERNEL_DIM
                     + int'(i_wt_kx))] <= i_wt_wdata;
      if (w_load_ok && i_bias_we && i_bias_idx < IDX_W'(NUM_OUTPUTS))
         r_bias[B_AW'(i_bias_idx)] <= i_bias_wdata;
      if (w_pix)
         r_out[OUT_AW'((int'(w_oc)*OUT_DIM + int'(w_oy))*OUT_DIM + int'(w_ox))] <= w_res;
   end

   for (genvar g = 0; g < NUM_INPUTS; g++) begin : g_lane
      logic signed [DATA_W-1:0] w_a, w_w;
      assign w_a = w_inb ? r_act[ACT_AW'((g*IN_DIM + w_iy)*IN_DIM + w_ix)] : '0;
      assign w_w = r_wt[WT_AW'(((int'(w_oc)*NUM_INPUTS + g)*KERNEL_DIM + int'(w_ky))*KERNEL_DIM
                               + int'(w_kx))];
      assign w_prod[g] = w_a * w_w;
   end

   assign w_first_tap = (w_ky == '0) && (w_kx == '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_INPUTS; i++) r_acc[i] <= '0;
      end else if (w_tap) begin
         for (int i = 0; i < NUM_INPUTS; i++)
            r_acc[i] <= (w_first_tap ? '0 : r_acc[i]) + ACC_W'(w_prod[i]);
      end
   end

   always_comb begin
      w_sum = 64'(r_bias[B_AW'(w_oc)]) <<< FRAC_W;
      for (int i = 0; i < NUM_INPUTS; i++) w_sum = w_sum + 64'(r_acc[i]);
      w_rnd = sat(round_hu(w_sum, FRAC_W), DATA_W);
      if (RELU_EN != 0 && w_rnd < 0) w_rnd = '0;
      w_res = DATA_W'(w_rnd);
   end

   always_comb begin
      o_rd_data = '0;
      if (i_rd_ch < IDX_W'(NUM_OUTPUTS) && i_rd_y < IDX_W'(OUT_DIM) && i_rd_x < IDX_W'(OUT_DIM))
         o_rd_data = r_out[OUT_AW'((int'(i_rd_ch)*OUT_DIM + int'(i_rd_y))*OUT_DIM + int'(i_rd_x))];
   end
endmodule

// File: tb/tb_conv_layer_fx.sv
// Directed + randomized bench for conv_layer_fx with 2 lanes, 2 kernels, stride 2, pad 1.
module tb_conv_layer_fx;
   localparam int NI = 2, NO = 2, ID = 5, K = 3, S = 2, P = 1;
   localparam int OD  = (ID + 2*P - K) / S + 1;
   localparam int LAT = NO*OD*OD*(K*K+1) + 1;

   logic        clk = 1'b0, rst_n = 1'b0, i_start = 1'b0;
   logic        o_busy, o_done;
   logic        i_act_we, i_wt_we, i_bias_we;
   logic [15:0] i_act_ch, i_act_y, i_act_x, i_act_wdata;
   logic [15:0] i_wt_in, i_wt_out, i_wt_ky, i_wt_kx, i_wt_wdata;
   logic [15:0] i_bias_idx, i_bias_wdata, i_rd_ch, i_rd_y, i_rd_x, o_rd_data;

   always #5 clk = ~clk;

   conv_layer_fx #(
      .NUM_INPUTS(NI), .NUM_OUTPUTS(NO), .IN_DIM(ID), .KERNEL_DIM(K), .STRIDE(S), .PAD(P),
      .DATA_W(16), .FRAC_W(8), .ACC_W(40), .RELU_EN(1)
   ) dut (
      .clk(clk), .rst_n(rst_n), .i_start(i_start), .o_busy(o_busy), .o_done(o_done),
      .i_act_we(i_act_we), .i_act_ch(i_act_ch), .i_act_y(i_act_y), .i_act_x(i_act_x),
      .i_act_wdata(i_act_wdata), .i_wt_we(i_wt_we), .i_wt_in(i_wt_in), .i_wt_out(i_wt_out),
      .i_wt_ky(i_wt_ky), .i_wt_kx(i_wt_kx), .i_wt_wdata(i_wt_wdata), .i_bias_we(i_bias_we),
      .i_bias_idx(i_bias_idx), .i_bias_wdata(i_bias_wdata), .i_rd_ch(i_rd_ch), .i_rd_y(i_rd_y),
      .i_rd_x(i_rd_x), .o_rd_data(o_rd_data)
   );

   int npass = 0, nfail = 0, nchk = 0;
   logic signed [15:0] m_act  [NI][ID][ID];
   logic signed [15:0] m_wt   [NO][NI][K][K];
   logic signed [15:0] m_bias [NO];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      nchk++;
      assert (obs === exp) npass++;
      else begin
         nfail++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   // Reference: direct convolution over the model arrays with Q8.8 rounding/saturation/ReLU.
   function automatic logic [15:0] ref_px(int oc, int oy, int ox);
      longint s = 0;
      for (int i = 0; i < NI; i++)
         for (int ky = 0; ky < K; ky++)
            for (int kx = 0; kx < K; kx++) begin
               int iy = oy*S + ky - P;
               int ix = ox*S + kx - P;
               if (iy >= 0 && iy < ID && ix >= 0 && ix < ID)
                  s += longint'(m_wt[oc][i][ky][kx]) * longint'(m_act[i][iy][ix]);
            end
      s += longint'(m_bias[oc]) * 256;
      s = (s + 128) >>> 8;
      if (s > 32767)  s = 32767;
      if (s < -32768) s = -32768;
      if (s < 0)      s = 0;
      return 16'(s);
   endfunction

   task automatic idle();
      i_start = 1'b0; i_act_we = 1'b0; i_wt_we = 1'b0; i_bias_we = 1'b0;
   endtask

   task automatic wr_act(input int c, input int y, input int x, input logic [15:0] d);
      i_act_we = 1'b1; i_act_ch = 16'(c); i_act_y = 16'(y); i_act_x = 16'(x); i_act_wdata = d;
      @(negedge clk); i_act_we = 1'b0;
   endtask

   task automatic wr_wt(input int o, input int i, input int ky, input int kx, input logic [15:0] d);
      i_wt_we = 1'b1; i_wt_out = 16'(o); i_wt_in = 16'(i); i_wt_ky = 16'(ky); i_wt_kx = 16'(kx);
      i_wt_wdata = d;
      @(negedge clk); i_wt_we = 1'b0;
   endtask

   // With go=1 the last bias write goes out together with start; wait_done takes the edge.
   task automatic load_all(input bit go);
      for (int c = 0; c < NI; c++)
         for (int y = 0; y < ID; y++)
            for (int x = 0; x < ID; x++) wr_act(c, y, x, m_act[c][y][x]);
      for (int o = 0; o < NO; o++)
         for (int i = 0; i < NI; i++)
            for (int ky = 0; ky < K; ky++)
               for (int kx = 0; kx < K; kx++) wr_wt(o, i, ky, kx, m_wt[o][i][ky][kx]);
      for (int o = 0; o < NO; o++) begin
         i_bias_we = 1'b1; i_bias_idx = 16'(o); i_bias_wdata = m_bias[o];
         if (go && o == NO-1) i_start = 1'b1;
         else begin @(negedge clk); i_bias_we = 1'b0; end
      end
   endtask

   task automatic wait_done(input int mode, input string tag);
      int  n = 0;
      bit  seen = 1'b0;
      while (!seen && n < 2000) begin
         @(negedge clk); n++; idle();
         if (n == 1) check({tag, "/done_clr"}, 64'(o_done), 64'd0);
         if (n == 2) check({tag, "/busy"}, 64'(o_busy), 64'd1);
         if (mode == 1 && n == 50) begin
            i_start = 1'b1; i_act_we = 1'b1; i_act_ch = 16'd0; i_act_y = 16'd2; i_act_x = 16'd2;
            i_act_wdata = 16'h1234;
         end
         seen = o_done;
      end
      check({tag, "/latency"}, 64'(n), 64'(LAT));
   endtask

   task automatic rd(input int c, input int y, input int x, output logic [15:0] d);
      i_rd_ch = 16'(c); i_rd_y = 16'(y); i_rd_x = 16'(x);
      #1 d = o_rd_data;
      @(negedge clk);
   endtask

   task automatic check_outputs(input string tag);
      logic [15:0] d;
      for (int oc = 0; oc < NO; oc++)
         for (int oy = 0; oy < OD; oy++)
            for (int ox = 0; ox < OD; ox++) begin
               rd(oc, oy, ox, d);
               check($sformatf("%s/out[%0d][%0d][%0d]", tag, oc, oy, ox), 64'(d),
                     64'(ref_px(oc, oy, ox)));
            end
   endtask

   task automatic fill_rand();
      for (int c = 0; c < NI; c++)
         for (int y = 0; y < ID; y++)
            for (int x = 0; x < ID; x++) m_act[c][y][x] = 16'($urandom_range(0, 4095)) - 16'd2048;
      for (int o = 0; o < NO; o++) begin
         m_bias[o] = 16'($urandom_range(0, 4095)) - 16'd2048;
         for (int i = 0; i < NI; i++)
            for (int ky = 0; ky < K; ky++)
               for (int kx = 0; kx < K; kx++) m_wt[o][i][ky][kx] = 16'($urandom_range(0, 4095)) - 16'd2048;
      end
   endtask

   task automatic fill_const(input logic [15:0] a, input logic [15:0] w, input logic [15:0] b);
      for (int c = 0; c < NI; c++)
         for (int y = 0; y < ID; y++)
            for (int x = 0; x < ID; x++) m_act[c][y][x] = a;
      for (int o = 0; o < NO; o++) begin
         m_bias[o] = b;
         for (int i = 0; i < NI; i++)
            for (int ky = 0; ky < K; ky++)
               for (int kx = 0; kx < K; kx++) m_wt[o][i][ky][kx] = w;
      end
   endtask

   initial begin
      logic [15:0] d;
      idle();
      i_act_ch = '0; i_act_y = '0; i_act_x = '0; i_act_wdata = '0;
      i_wt_in = '0; i_wt_out = '0; i_wt_ky = '0; i_wt_kx = '0; i_wt_wdata = '0;
      i_bias_idx = '0; i_bias_wdata = '0; i_rd_ch = '0; i_rd_y = '0; i_rd_x = '0;
      repeat (2) @(negedge clk);
      check("reset/busy", 64'(o_busy), 64'd0);
      check("reset/done", 64'(o_done), 64'd0);
      rst_n = 1'b1;
      @(negedge clk);
      rd(NO, 0, 0, d);  check("rd_oob_ch", 64'(d), 64'd0);
      rd(0, 0, OD, d);  check("rd_oob_x", 64'(d), 64'd0);

      // Random set A, then out-of-range writes that must not alias into valid entries.
      fill_rand();
      load_all(1'b0);
      wr_act(0, 0, ID, 16'h7777);
      wr_wt(0, 0, 0, K, 16'h7777);
      wr_wt(NO, 0, 0, 0, 16'h7777);
      i_start = 1'b1;
      wait_done(0, "randA");
      check_outputs("randA");

      // Restart from DONE; start and an activation write while busy are both ignored.
      i_start = 1'b1;
      wait_done(1, "restart");
      check_outputs("restart");

      fill_const(16'h7F00, 16'h7F00, 16'h0000);
      load_all(1'b1);
      wait_done(0, "satpos");
      check_outputs("satpos");
      rd(0, 1, 1, d); check("satpos/centre", 64'(d), 64'h7FFF);

      fill_const(16'h7F00, 16'h8100, 16'h0000);
      load_all(1'b1);
      wait_done(0, "satneg");
      check_outputs("satneg");
      rd(1, 1, 1, d); check("satneg/relu", 64'(d), 64'h0000);

      // x.5 LSB rounding across two lanes with a -0.5 bias on kernel 1.
      fill_const(16'h0000, 16'h0000, 16'h0000);
      m_wt[1][0][1][1] = 16'h0080; m_act[0][0][0] = 16'h0003;
      m_wt[1][1][1][1] = 16'h0100; m_act[1][0][0] = 16'h0200;
      m_bias[1] = 16'hFF80;
      load_all(1'b1);
      wait_done(0, "round");
      check_outputs("round");
      rd(1, 0, 0, d); check("round/px", 64'(d), 64'h0182);

      // Asynchronous reset mid-run, then a full run whose final load coincides with start.
      i_start = 1'b1;
      repeat (30) begin @(negedge clk); idle(); end
      rst_n = 1'b0;
      #1;
      check("midreset/busy", 64'(o_busy), 64'd0);
      check("midreset/done", 64'(o_done), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("postreset/busy", 64'(o_busy), 64'd0);
      fill_rand();
      load_all(1'b1);
      wait_done(0, "randB");
      check_outputs("randB");

      $display("%0d/%0d checks passed", npass, nchk);
      $finish;
   end
endmodule
